freq_seg_scan: RTL and testbench

Display stage directly downstream of the frequency counter. Takes the six BCD frequency digits (units through lac), resynchronises them into the `clk100` domain, and latches them into a display shadow once they are stable. It then drives a six-digit, time-multiplexed, common-anode 7-segment display with leading-zero blanking, an optional decimal point, an invalid-digit indicator and anti-ghosting blank slots.

---
 rtl/freq_seg_scan.sv | 75 +++++++
 tb/tb_freq_seg_scan.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/freq_seg_scan.sv
// freq_seg_scan: resynchronise six BCD digits, debounce into a shadow, and scan a 6-digit common-anode display
module freq_seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int STABLE_CYC = 16,
  parameter int DP_POS = 6
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic [3:0] fre_num_u,
  input  logic [3:0] fre_num_d,
  input  logic [3:0] fre_num_h,
  input  logic [3:0] fre_num_t,
  input  logic [3:0] fre_num_m,
  input  logic [3:0] fre_num_l,
  output logic [7:0] seg,
  output logic [5:0] an,
  output logic       disp_updated
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(STABLE_CYC);
  logic [23:0] sync1, sync2, smp, shadow, rest;
  logic [SW-1:0] stab_cnt;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] pat, dig;
  logic blank, load, lit;
  // rest holds the current digit in its low nibble and every higher digit above it
  always_comb begin
    rest = shadow >> {idx, 2'b00};
    blank = idx != 3'd0 && rest == 24'd0;
    load = sync2 == smp && stab_cnt == SW'(STABLE_CYC - 2);
    lit = cnt >= CW'(BLANK_CYC) && !blank;
    case (rest[3:0])
      4'd0: pat = 8'hC0;
      4'd1: pat = 8'hF9;
      4'd2: pat = 8'hA4;
      4'd3: pat = 8'hB0;
      4'd4: pat = 8'h99;
      4'd5: pat = 8'h92;
      4'd6: pat = 8'h82;
      4'd7: pat = 8'hF8;
      4'd8: pat = 8'h80;
      4'd9: pat = 8'h90;
      default: pat = 8'hBF;
    endcase
    dig = idx == 3'(DP_POS) ? pat & 8'h7F : pat;
  end
  always_ff @(posedge clk100) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      smp <= '0;
      shadow <= '0;
      stab_cnt <= '0;
      disp_updated <= 1'b0;
      cnt <= '0;
      idx <= '0;
      seg <= 8'hFF;
      an <= 6'h3F;
    end else begin
      // packed in digit-index order: units in the lowest nibble, lac in the highest
      sync1 <= {fre_num_l, fre_num_m, fre_num_t, fre_num_h, fre_num_d, fre_num_u};
      sync2 <= sync1;
      smp <= sync2;
      stab_cnt <= sync2 != smp ? '0 : stab_cnt == SW'(STABLE_CYC - 1) ? stab_cnt : stab_cnt + 1'b1;
      if (load) shadow <= sync2;
      disp_updated <= load && sync2 != shadow;
      cnt <= cnt == CW'(SCAN_DIV - 1) ? '0 : cnt + 1'b1;
      if (cnt == CW'(SCAN_DIV - 1)) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
      seg <= lit ? dig : 8'hFF;
      an <= lit ? ~(6'd1 << idx) : 6'h3F;
    end
  end
endmodule

// File: tb/tb_freq_seg_scan.sv
// tb_freq_seg_scan: directed scoreboard bench; expected lit slots are queued per frame and matched by a monitor
module tb_freq_seg_scan;
  logic clk100 = 1'b0, rst = 1'b1;
  logic [3:0] fre_num_u = '0, fre_num_d = '0, fre_num_h = '0, fre_num_t = '0, fre_num_m = '0, fre_num_l = '0;
  logic [7:0] seg;
  logic [5:0] an;
  logic disp_updated;
  int checks = 0, errors = 0, cyc = 0, upd_cnt = 0, run_len = 0;
  logic [13:0] exp_q[$];
  logic [13:0] cur;
  logic [5:0] prev_an = 6'h3F;
  logic armed = 1'b0, in_run = 1'b0;

  freq_seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .STABLE_CYC(4), .DP_POS(3)) dut (
    .clk100(clk100), .rst(rst),
    .fre_num_u(fre_num_u), .fre_num_d(fre_num_d), .fre_num_h(fre_num_h),
    .fre_num_t(fre_num_t), .fre_num_m(fre_num_m), .fre_num_l(fre_num_l),
    .seg(seg), .an(an), .disp_updated(disp_updated)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // monitor: each lit run that starts while armed pops one expected {an,seg}
  always @(negedge clk100) begin
    if (disp_updated) upd_cnt++;
    if (armed && an != 6'h3F && prev_an == 6'h3F) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_slot got an=%b seg=%h want dark", an, seg);
      end else begin
        cur = exp_q.pop_front();
        in_run = 1'b1;
        run_len = 0;
      end
    end
    if (in_run && an != 6'h3F) begin
      run_len++;
      chk("slot_an_seg", {18'd0, an, seg}, {18'd0, cur});
    end
    if (in_run && an == 6'h3F) begin
      chk("slot_len", run_len, 6);
      in_run = 1'b0;
    end
    if (armed && an == 6'h3F) chk("dark_seg", seg, 8'hFF);
    prev_an = an;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic set_dig(input logic [23:0] v);
    {fre_num_l, fre_num_m, fre_num_t, fre_num_h, fre_num_d, fre_num_u} = v;
  endtask

  task automatic apply(input string name, input logic [23:0] v, input int pulses);
    int u0;
    u0 = upd_cnt;
    set_dig(v);
    tick(12);
    chk(name, upd_cnt - u0, pulses);
  endtask

  task automatic frame(input string name, input int n, input logic [47:0] segs, input logic [5:0] lit);
    do tick(1); while (cyc % 48 != 0);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < 6; i++)
        if (lit[i]) exp_q.push_back({~(6'd1 << i), segs[8*i +: 8]});
    armed = 1'b1;
    tick(48 * n + 2);
    armed = 1'b0;
    chk({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int u0, lat;
    tick(4);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 6'h3F);
    chk("rst_upd", disp_updated, 0);
    rst = 1'b0;
    tick(20);
    // digits slot5..slot0 = 0,1,3,2,4,5
    u0 = upd_cnt;
    lat = 0;
    set_dig(24'h013245);
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (disp_updated && lat == 0) lat = i;
    end
    checks++;
    if (lat < 5 || lat > 6) begin
      errors++;
      $display("FAIL load_latency got %0d want 5..6", lat);
    end
    chk("load_pulses", upd_cnt - u0, 1);
    frame("digits", 1, {8'hFF, 8'hF9, 8'h30, 8'hA4, 8'h99, 8'h92}, 6'b011111);
    // reset in the middle of a slot and of a stable run
    tick(13);
    u0 = upd_cnt;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("midrst_seg", seg, 8'hFF);
      chk("midrst_an", an, 6'h3F);
      chk("midrst_upd", disp_updated, 0);
    end
    rst = 1'b0;
    tick(1);
    chk("post_rst_c1", an, 6'h3F);
    tick(1);
    chk("post_rst_c2", an, 6'h3F);
    tick(1);
    chk("post_rst_an", an, 6'h3E);
    chk("post_rst_seg", seg, 8'hC0);
    tick(12);
    chk("post_rst_reload", upd_cnt - u0, 1);
    apply("zero_pulse", 24'h000000, 1);
    frame("zero", 1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, 6'b000001);
    apply("seven_pulse", 24'h000007, 1);
    frame("seven", 1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8}, 6'b000001);
    u0 = upd_cnt;
    for (int k = 0; k < 20; k++) begin
      set_dig(k % 2 ? 24'h654321 : 24'h987654);
      tick(2);
    end
    chk("glitch_none", upd_cnt - u0, 0);
    apply("glitch_hold", 24'h654321, 1);
    frame("hold", 1, {8'h82, 8'h92, 8'h19, 8'hB0, 8'hA4, 8'hF9}, 6'b111111);
    apply("invalid_pulse", 24'h000C00, 1);
    frame("invalid", 1, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0, 8'hC0}, 6'b000111);
    set_dig(24'h111111);
    tick(2);
    apply("same_reload", 24'h000C00, 0);
    frame("two_frames", 2, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0, 8'hC0}, 6'b000111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
